smi_tx_sched: RTL and testbench

- Read-side scheduler for the SMI TX FIFO.
- Pops 16-bit words that the SMI receive path pushed, checks the sync-bit framing, and pairs them into 32-bit I/Q samples.
- Presents each sample to the modem TX interface on a valid/ready handshake.
- Handles prefill gating before streaming, resynchronisation after framing errors, underrun accounting, and latching of the per-sample TX control bits.

---
 rtl/smi_tx_pkg.sv | 21 ++
 rtl/sat_counter.sv | 28 ++
 rtl/smi_tx_sched.sv | 140 ++++++++++++++
 tb/tb_smi_tx_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/smi_tx_pkg.sv
// rtl/smi_tx_pkg.sv - shared state encoding and field constants for the SMI TX scheduler
// Contents: state_e (scheduler FSM states), SAMPLE_W/WORD_W widths,
//           SYNC_BIT/COND_BIT/CTRL_BIT bit positions within a 16-bit FIFO word.
package smi_tx_pkg;

  localparam int SAMPLE_W = 32;
  localparam int WORD_W   = 16;

  localparam int SYNC_BIT = 0;
  localparam int COND_BIT = 5;
  localparam int CTRL_BIT = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_HI      = 3'd2,
    ST_LO      = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk_i clock, rst_b_i async active-low reset, inc_i increment request,
//        clr_i synchronous clear (wins over inc_i), cnt_o current count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_b_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/smi_tx_sched.sv
// rtl/smi_tx_sched.sv - SMI TX FIFO read scheduler: sync framing, I/Q pairing, modem handshake
// Optional build macro: SMI_TX_SCHED_ZERO_FILL_EN (present zero samples while waiting for data).
// Ports: i_sys_clk clock, i_rst_b async active-low reset, i_enable stream enable,
//        i_prefill_thr start level, i_cnt_clear counter clear,
//        i_fifo_data/i_fifo_empty/i_fifo_level FWFT FIFO head, o_fifo_pull pop strobe,
//        o_sample/o_sample_valid/i_sample_ready modem sample handshake,
//        o_cond_tx/o_modem_tx_ctrl control bits of last delivered sample,
//        o_streaming FSM in HI/LO/OUT, o_underrun_cnt/o_sync_err_cnt saturating counters.
module smi_tx_sched
  import smi_tx_pkg::*;
#(
  parameter int FIFO_AW = 10,
  parameter int CNT_W   = 16
) (
  input  logic                i_sys_clk,
  input  logic                i_rst_b,
  input  logic                i_enable,
  input  logic [FIFO_AW:0]    i_prefill_thr,
  input  logic                i_cnt_clear,
  input  logic [WORD_W-1:0]   i_fifo_data,
  input  logic                i_fifo_empty,
  input  logic [FIFO_AW:0]    i_fifo_level,
  output logic                o_fifo_pull,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_sample_valid,
  input  logic                i_sample_ready,
  output logic                o_cond_tx,
  output logic                o_modem_tx_ctrl,
  output logic                o_streaming,
  output logic [CNT_W-1:0]    o_underrun_cnt,
  output logic [CNT_W-1:0]    o_sync_err_cnt
);

`ifdef SMI_TX_SCHED_ZERO_FILL_EN
  localparam logic FILL_EN = 1'b1;
`else
  localparam logic FILL_EN = 1'b0;
`endif

  state_e              state_q;
  logic [WORD_W-1:0]   hi_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;
  logic                cond_q;
  logic                ctrl_q;

  logic in_hi, in_lo, head_ok, sync_bit;
  logic sync_err_inc, underrun_inc, fill_active;

  assign in_hi    = (state_q == ST_HI);
  assign in_lo    = (state_q == ST_LO);
  assign head_ok  = i_enable && !i_fifo_empty;
  assign sync_bit = i_fifo_data[SYNC_BIT];

  // A hi word is always consumed (latched or discarded); in ST_LO a word with
  // the sync bit set is left in the FIFO so ST_HI can re-examine it.
  assign o_fifo_pull  = head_ok && (in_hi || (in_lo && !sync_bit));
  assign sync_err_inc = head_ok && ((in_hi && !sync_bit) || (in_lo && sync_bit));
  assign underrun_inc = i_enable && i_sample_ready && (in_hi || in_lo);
  assign fill_active  = FILL_EN && (in_hi || in_lo);

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      cond_q   <= 1'b0;
      ctrl_q   <= 1'b0;
    end else if (!i_enable) begin
      // Disable drops any partial or pending sample.
      state_q  <= ST_IDLE;
      sample_q <= '0;
      valid_q  <= 1'b0;
      cond_q   <= 1'b0;
      ctrl_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_PREFILL;
        ST_PREFILL: begin
          if (i_fifo_level >= i_prefill_thr) begin
            state_q <= ST_HI;
            valid_q <= FILL_EN;
            if (FILL_EN) sample_q <= '0;
          end
        end
        ST_HI: begin
          if (!i_fifo_empty && sync_bit) begin
            hi_q    <= i_fifo_data;
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          if (!i_fifo_empty) begin
            if (!sync_bit) begin
              sample_q <= {hi_q, i_fifo_data};
              valid_q  <= 1'b1;
              state_q  <= ST_OUT;
            end else begin
              state_q <= ST_HI;
            end
          end
        end
        ST_OUT: begin
          if (i_sample_ready) begin
            cond_q  <= sample_q[WORD_W+COND_BIT];
            ctrl_q  <= sample_q[WORD_W+CTRL_BIT];
            valid_q <= FILL_EN;
            if (FILL_EN) sample_q <= '0;
            state_q <= ST_HI;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_sample        = sample_q;
  assign o_sample_valid  = valid_q;
  assign o_cond_tx       = cond_q && !fill_active;
  assign o_modem_tx_ctrl = ctrl_q && !fill_active;
  assign o_streaming     = in_hi || in_lo || (state_q == ST_OUT);

  sat_counter #(.W(CNT_W)) u_underrun_cnt (
    .clk_i   (i_sys_clk),
    .rst_b_i (i_rst_b),
    .inc_i   (underrun_inc),
    .clr_i   (i_cnt_clear),
    .cnt_o   (o_underrun_cnt)
  );

  sat_counter #(.W(CNT_W)) u_sync_err_cnt (
    .clk_i   (i_sys_clk),
    .rst_b_i (i_rst_b),
    .inc_i   (sync_err_inc),
    .clr_i   (i_cnt_clear),
    .cnt_o   (o_sync_err_cnt)
  );

endmodule

// File: tb/tb_smi_tx_sched.sv
// tb/tb_smi_tx_sched.sv - scoreboard testbench for smi_tx_sched
module tb_smi_tx_sched;

  localparam int FIFO_AW = 10;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              enable = 1'b0;
  logic [FIFO_AW:0]  thr = '0;
  logic              cnt_clear = 1'b0;
  logic [15:0]       fdata = 16'h0;
  logic              fempty = 1'b1;
  logic [FIFO_AW:0]  level = '0;
  logic              pull;
  logic [31:0]       sample;
  logic              valid;
  logic              sample_ready = 1'b0;
  logic              cond, ctrl, streaming;
  logic [CNT_W-1:0]  und_cnt, serr_cnt;

  always #5 clk = ~clk;

  smi_tx_sched #(.FIFO_AW(FIFO_AW), .CNT_W(CNT_W)) dut (
    .i_sys_clk       (clk),
    .i_rst_b         (rst_b),
    .i_enable        (enable),
    .i_prefill_thr   (thr),
    .i_cnt_clear     (cnt_clear),
    .i_fifo_data     (fdata),
    .i_fifo_empty    (fempty),
    .i_fifo_level    (level),
    .o_fifo_pull     (pull),
    .o_sample        (sample),
    .o_sample_valid  (valid),
    .i_sample_ready  (sample_ready),
    .o_cond_tx       (cond),
    .o_modem_tx_ctrl (ctrl),
    .o_streaming     (streaming),
    .o_underrun_cnt  (und_cnt),
    .o_sync_err_cnt  (serr_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FWFT FIFO model: pops registered at the clock edge, applied with pushes at negedge.
  logic [15:0] fq[$];
  logic [15:0] push_q[$];
  logic        pop_pending = 1'b0;

  always @(posedge clk) pop_pending <= pull;

  always @(negedge clk) begin
    if (pop_pending && fq.size() > 0) void'(fq.pop_front());
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    fempty = (fq.size() == 0);
    fdata  = fempty ? 16'h0 : fq[0];
    level  = (FIFO_AW+1)'(fq.size());
  end

  task automatic push(input logic [15:0] w);
    push_q.push_back(w);
  endtask

  // Scoreboard: expected sample plus the control bits it should leave behind.
  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        t;
  } exp_t;
  exp_t exp_q[$];
  exp_t last;
  logic sink_en = 1'b0;
  logic chk_ctl = 1'b0;

  task automatic expect_sample(input logic [15:0] hi, input logic [15:0] lo);
    exp_t e;
    e.s = {hi, lo};
    e.c = hi[5];
    e.t = hi[6];
    exp_q.push_back(e);
  endtask

  // Sink + monitor: ready follows valid; a handshake is judged before the edge that takes it.
  always @(negedge clk) begin
    if (chk_ctl) begin
      check("cond_tx", cond, last.c);
      check("modem_tx_ctrl", ctrl, last.t);
      chk_ctl = 1'b0;
    end
    if (sink_en) sample_ready = valid;
    if (valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got %h expected none", sample);
      end else begin
        last = exp_q.pop_front();
        check("sample", sample, last.s);
        chk_ctl = 1'b1;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_sample", sample, 32'h0);
    check("rst_valid", valid, 0);
    check("rst_pull", pull, 0);
    check("rst_cond", cond, 0);
    check("rst_ctrl", ctrl, 0);
    check("rst_underrun", und_cnt, 0);
    check("rst_sync_err", serr_cnt, 0);
    check("rst_streaming", streaming, 0);

    rst_b = 1'b1;
    thr = 11'd4;
    enable = 1'b1;
    sink_en = 1'b1;

    // Prefill gating
    expect_sample(16'h8001, 16'h1234);
    expect_sample(16'h0061, 16'hAAAA);
    expect_sample(16'h0001, 16'h5554);
    push(16'h8001); push(16'h1234); push(16'h0061);
    repeat (6) @(negedge clk);
    check("prefill_gate", streaming, 0);
    push(16'hAAAA);
    repeat (2) @(negedge clk);
    check("prefill_pass", streaming, 1);
    push(16'h0001); push(16'h5554);
    drain("normal");

    // Resync loop
    expect_sample(16'h0003, 16'h0010);
    push(16'h0002); push(16'h0004); push(16'h0003); push(16'h0010);
    drain("resync");
    check("resync_sync_err", serr_cnt, 2);

    // Double hi word
    expect_sample(16'h0005, 16'h0006);
    push(16'h0003); push(16'h0005); push(16'h0006);
    drain("double_hi");
    check("double_hi_sync_err", serr_cnt, 3);

    // Underrun with empty FIFO
    sink_en = 1'b0;
    check("pre_underrun", und_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) sample_ready = 1'b1;
      @(negedge clk) sample_ready = 1'b0;
    end
    @(negedge clk);
    check("underrun_cnt", und_cnt, 5);
    check("underrun_streaming", streaming, 1);
    cnt_clear = 1'b1;
    @(negedge clk) cnt_clear = 1'b0;
    @(negedge clk);
    check("clear_underrun", und_cnt, 0);
    check("clear_sync_err", serr_cnt, 0);
    sink_en = 1'b1;

    // Disable while holding a hi word
    push(16'h0021);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_idle", streaming, 0);
    thr = '0;
    enable = 1'b1;
    expect_sample(16'h0041, 16'h0002);
    push(16'h0008); push(16'h0041); push(16'h0002);
    drain("after_disable");
    check("lost_hi_sync_err", serr_cnt, 1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("disable_ctrl_clear", ctrl, 0);
    check("disable_cnt_held", serr_cnt, 1);

    // Async reset while a sample waits in ST_OUT
    sink_en = 1'b0;
    sample_ready = 1'b0;
    enable = 1'b1;
    push(16'h0061); push(16'h0010);
    n = 0;
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid", valid, 1);
    check("out_sample", sample, 32'h0061_0010);
    #2 rst_b = 1'b0;
    #1;
    check("async_rst_sample", sample, 32'h0);
    check("async_rst_valid", valid, 0);
    check("async_rst_streaming", streaming, 0);
    check("async_rst_counters", {und_cnt, serr_cnt}, 32'h0);
    check("async_rst_cond_ctrl", {cond, ctrl}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
